// File: rtl/rom_arbiter_if.sv
// Bus bundle between two ROM requesters, the arbiter and the combinational ROM.
// The arbiter side uses the slave modport; the requester/ROM side uses master.
interface rom_arbiter_if;
   localparam int unsigned AW = 12;
   localparam int unsigned DW = 8;

   logic          req0;
   logic [AW-1:0] addr0;
   logic          len0;
   logic          gnt0;
   logic          req1;
   logic [AW-1:0] addr1;
   logic          len1;
   logic          gnt1;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_id;
   logic          rd_last;
   logic          busy;

   modport slave (
      input  req0, addr0, len0, req1, addr1, len1, rom_data,
      output gnt0, gnt1, rom_addr, rd_data, rd_valid, rd_id, rd_last, busy
   );

   modport master (
      output req0, addr0, len0, req1, addr1, len1, rom_data,
      input  gnt0, gnt1, rom_addr, rd_data, rd_valid, rd_id, rd_last, busy
   );
endinterface

// File: rtl/rom_arbiter.sv
// Two-requester round-robin arbiter in front of a combinational ROM.
// Delivers one or two consecutive bytes per grant; no queueing while busy.
module rom_arbiter (
   input  logic         clk,
   input  logic         rst,
   rom_arbiter_if.slave bus
);
   localparam int unsigned AW = 12;
   localparam int unsigned DW = 8;

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          len_q, len_d;
   logic          id_q, id_d;
   logic          last_id_q, last_id_d;
   logic          gnt0_q, gnt0_d;
   logic          gnt1_q, gnt1_d;
   logic [DW-1:0] rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          rd_id_q, rd_id_d;
   logic          rd_last_q, rd_last_d;
   logic          busy_q, busy_d;
   logic          win;

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      id_d       = id_q;
      last_id_d  = last_id_q;
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      rd_id_d    = rd_id_q;
      rd_last_d  = rd_last_q;
      busy_d     = 1'b0;
      win        = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               // On contention the requester served least recently wins
               win       = (bus.req0 && bus.req1) ? ~last_id_q : bus.req1;
               id_d      = win;
               last_id_d = win;
               addr_d    = win ? bus.addr1 : bus.addr0;
               len_d     = win ? bus.len1 : bus.len0;
               gnt0_d    = ~win;
               gnt1_d    = win;
               busy_d    = 1'b1;
               state_d   = BEAT0;
            end
         end
         BEAT0: begin
            rd_valid_d = 1'b1;
            rd_data_d  = bus.rom_data;
            rd_id_d    = id_q;
            rd_last_d  = ~len_q;
            if (len_q) begin
               addr_d  = addr_q + AW'(1);
               busy_d  = 1'b1;
               state_d = BEAT1;
            end else begin
               state_d = IDLE;
            end
         end
         BEAT1: begin
            rd_valid_d = 1'b1;
            rd_data_d  = bus.rom_data;
            rd_id_d    = id_q;
            rd_last_d  = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         len_q      <= 1'b0;
         id_q       <= 1'b0;
         last_id_q  <= 1'b1;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_id_q    <= 1'b0;
         rd_last_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         id_q       <= id_d;
         last_id_q  <= last_id_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_id_q    <= rd_id_d;
         rd_last_q  <= rd_last_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.gnt0     = gnt0_q;
   assign bus.gnt1     = gnt1_q;
   assign bus.rom_addr = addr_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_id    = rd_id_q;
   assign bus.rd_last  = rd_last_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: single/double reads, address wrap, contention,
// busy-time requests, reset abort and idle behaviour against a pattern ROM.
module tb_rom_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   order[4];
   int   ngnt;

   rom_arbiter_if bus ();

   rom_arbiter u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_f(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
   endfunction

   assign bus.rom_data = rom_f(bus.rom_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.req0 = 1'b0; bus.addr0 = '0; bus.len0 = 1'b0;
      bus.req1 = 1'b0; bus.addr1 = '0; bus.len1 = 1'b0;

      // Reset values
      rst = 1'b1;
      tick();
      tick();
      chk("rst_gnt0", 32'(bus.gnt0), 0);
      chk("rst_gnt1", 32'(bus.gnt1), 0);
      chk("rst_valid", 32'(bus.rd_valid), 0);
      chk("rst_data", 32'(bus.rd_data), 0);
      chk("rst_id", 32'(bus.rd_id), 0);
      chk("rst_last", 32'(bus.rd_last), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_addr", 32'(bus.rom_addr), 0);
      rst = 1'b0;

      // Single-byte read by requester 0
      bus.req0 = 1'b1; bus.addr0 = 12'h005; bus.len0 = 1'b0;
      tick();
      chk("s_gnt0", 32'(bus.gnt0), 1);
      chk("s_gnt1", 32'(bus.gnt1), 0);
      chk("s_busy", 32'(bus.busy), 1);
      chk("s_valid0", 32'(bus.rd_valid), 0);
      chk("s_addr", 32'(bus.rom_addr), 32'h005);
      bus.req0 = 1'b0;
      tick();
      chk("s_valid", 32'(bus.rd_valid), 1);
      chk("s_data", 32'(bus.rd_data), 32'(rom_f(12'h005)));
      chk("s_id", 32'(bus.rd_id), 0);
      chk("s_last", 32'(bus.rd_last), 1);
      chk("s_busy_end", 32'(bus.busy), 0);
      chk("s_gnt0_end", 32'(bus.gnt0), 0);
      tick();
      chk("s_valid_off", 32'(bus.rd_valid), 0);
      chk("s_data_hold", 32'(bus.rd_data), 32'(rom_f(12'h005)));

      // Two-byte read by requester 1 wrapping 0xFFF -> 0x000
      bus.req1 = 1'b1; bus.addr1 = 12'hFFF; bus.len1 = 1'b1;
      tick();
      chk("w_gnt1", 32'(bus.gnt1), 1);
      chk("w_gnt0", 32'(bus.gnt0), 0);
      chk("w_addr0", 32'(bus.rom_addr), 32'hFFF);
      bus.req1 = 1'b0;
      tick();
      chk("w_valid0", 32'(bus.rd_valid), 1);
      chk("w_data0", 32'(bus.rd_data), 32'(rom_f(12'hFFF)));
      chk("w_id0", 32'(bus.rd_id), 1);
      chk("w_last0", 32'(bus.rd_last), 0);
      chk("w_addr1", 32'(bus.rom_addr), 32'h000);
      chk("w_busy1", 32'(bus.busy), 1);
      chk("w_gnt1_off", 32'(bus.gnt1), 0);
      tick();
      chk("w_valid1", 32'(bus.rd_valid), 1);
      chk("w_data1", 32'(bus.rd_data), 32'(rom_f(12'h000)));
      chk("w_id1", 32'(bus.rd_id), 1);
      chk("w_last1", 32'(bus.rd_last), 1);
      chk("w_busy_end", 32'(bus.busy), 0);
      tick();
      chk("w_valid_off", 32'(bus.rd_valid), 0);

      // Requester 1 asserts only while a requester-0 burst is in flight
      bus.req0 = 1'b1; bus.addr0 = 12'h100; bus.len0 = 1'b1;
      tick();
      chk("b_gnt0", 32'(bus.gnt0), 1);
      bus.req0 = 1'b0;
      bus.req1 = 1'b1; bus.addr1 = 12'h200; bus.len1 = 1'b0;
      tick();
      chk("b_gnt1_a", 32'(bus.gnt1), 0);
      chk("b_id_a", 32'(bus.rd_id), 0);
      chk("b_data_a", 32'(bus.rd_data), 32'(rom_f(12'h100)));
      tick();
      bus.req1 = 1'b0;
      chk("b_gnt1_b", 32'(bus.gnt1), 0);
      chk("b_valid_b", 32'(bus.rd_valid), 1);
      chk("b_id_b", 32'(bus.rd_id), 0);
      chk("b_data_b", 32'(bus.rd_data), 32'(rom_f(12'h101)));
      chk("b_busy_b", 32'(bus.busy), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("b_gnt1_idle", 32'(bus.gnt1), 0);
         chk("b_valid_idle", 32'(bus.rd_valid), 0);
         chk("b_busy_idle", 32'(bus.busy), 0);
      end

      // Contention from reset: grants must alternate starting with 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.addr0 = 12'h010; bus.len0 = 1'b0;
      bus.addr1 = 12'h020; bus.len1 = 1'b0;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      ngnt = 0;
      for (int c = 0; c < 40 && ngnt < 4; c++) begin
         tick();
         chk("c_excl", 32'(bus.gnt0 & bus.gnt1), 0);
         if (bus.gnt0) begin
            order[ngnt] = 0;
            ngnt++;
            bus.req0 = 1'b0;
         end else begin
            bus.req0 = 1'b1;
         end
         if (bus.gnt1) begin
            order[ngnt] = 1;
            ngnt++;
            bus.req1 = 1'b0;
         end else begin
            bus.req1 = 1'b1;
         end
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      chk("c_count", 32'(ngnt), 4);
      if (ngnt == 4) begin
         chk("c_order0", 32'(order[0]), 0);
         chk("c_order1", 32'(order[1]), 1);
         chk("c_order2", 32'(order[2]), 0);
         chk("c_order3", 32'(order[3]), 1);
      end
      tick();
      tick();

      // Reset during BEAT0 of a two-byte read aborts the transfer
      bus.req1 = 1'b1; bus.addr1 = 12'h300; bus.len1 = 1'b1;
      tick();
      chk("r_gnt1", 32'(bus.gnt1), 1);
      bus.req1 = 1'b0;
      rst = 1'b1;
      bus.req0 = 1'b1; bus.addr0 = 12'h040; bus.len0 = 1'b0;
      tick();
      rst = 1'b0;
      bus.req0 = 1'b0;
      chk("r_busy", 32'(bus.busy), 0);
      chk("r_valid", 32'(bus.rd_valid), 0);
      chk("r_addr", 32'(bus.rom_addr), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("r_valid_after", 32'(bus.rd_valid), 0);
         chk("r_busy_after", 32'(bus.busy), 0);
         chk("r_gnt0_after", 32'(bus.gnt0), 0);
      end

      // Idle for 20 cycles
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("i_gnt0", 32'(bus.gnt0), 0);
         chk("i_gnt1", 32'(bus.gnt1), 0);
         chk("i_valid", 32'(bus.rd_valid), 0);
         chk("i_busy", 32'(bus.busy), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; both are sampled on the rising edge of clk.
REQ-002 The ports SHALL be as follows, one per line:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0  in  1  requester 0 (instruction fetch) request
- addr0  in  12  requester 0 start address
- len0  in  1  requester 0 length: 0=1 byte, 1=2 bytes
- gnt0  out  1  requester 0 grant pulse
- req1  in  1  requester 1 (data/loader read) request
- addr1  in  12  requester 1 start address
- len1  in  1  requester 1 length: 0=1 byte, 1=2 bytes
- gnt1  out  1  requester 1 grant pulse
- rom_addr  out  12  address to the combinational ROM
- rom_data  in  8  ROM read data (combinational from rom_addr)
- rd_data  out  8  registered read byte
- rd_valid  out  1  rd_data valid, one-cycle pulse per byte
- rd_id  out  1  requester owning rd_data
- rd_last  out  1  final byte of the transfer
- busy  out  1  FSM not in IDLE

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BEAT0 and BEAT1.
REQ-004 In IDLE with any reqX sampled high, the FSM SHALL latch the winner's address, length and id, and move to BEAT0 at the next edge.
REQ-005 The gnt of the winner SHALL be high for exactly the first cycle in BEAT0, and all other gnt signals SHALL be low.
REQ-006 When both req0 and req1 are high in IDLE, the winner SHALL be the requester not recorded in last_id; last_id SHALL update to the winner on each grant.
REQ-007 A single request SHALL win regardless of last_id.
REQ-008 rom_addr SHALL equal the latched address register in every state.
REQ-009 In BEAT0, the block SHALL capture rom_data into rd_data at the edge, with rd_valid=1, rd_id=winner and rd_last=~len in the following cycle.
REQ-010 From BEAT0, the FSM SHALL go to BEAT1 if len=1; otherwise it SHALL go to IDLE.
REQ-011 Entering BEAT1 SHALL increment the address register by 1 modulo 4096, so 0xFFF wraps to 0x000.
REQ-012 In BEAT1, the block SHALL capture rom_data, with rd_valid=1 and rd_last=1 in the following cycle; the FSM SHALL then go to IDLE.
REQ-013 Latency SHALL be: req sampled in cycle N gives gnt in N+1 and the first byte valid in N+2; a second byte, if requested, is valid in N+3.
REQ-014 A requester SHALL deassert req in the cycle its gnt is high; req still high when the FSM next samples in IDLE SHALL be treated as a new request.
REQ-015 Requests arriving while busy=1 SHALL be ignored until IDLE; there is no queueing.
REQ-016 The FSM SHALL spend at least one cycle in IDLE between transfers.
REQ-017 rd_valid SHALL be low in every cycle not covered by REQ-009 or REQ-012; rd_data, rd_id and rd_last SHALL hold their last values when rd_valid is low.
REQ-018 busy SHALL be 1 in BEAT0 and BEAT1, and 0 in IDLE.

Reset
REQ-019 With rst high at an edge, the block SHALL set state=IDLE, address register=0x000, last_id=1, gnt0=gnt1=0, rd_valid=0, rd_data=0x00, rd_id=0, rd_last=0 and busy=0.
REQ-020 Reset SHALL abort any transfer in progress, with no further rd_valid for that transfer.
REQ-021 Requests sampled in the same cycle as rst SHALL be ignored.

Verification
REQ-022 Single-byte read: req0=1, addr0=0x005, len0=0 in cycle N -> gnt0=1 in N+1; rd_valid=1, rd_data=ROM[0x005], rd_id=0, rd_last=1 in N+2; busy=0 in N+2.
REQ-023 Two-byte read with wrap: req1=1, addr1=0xFFF, len1=1 -> rd_data=ROM[0xFFF] with rd_last=0, then ROM[0x000] with rd_last=1, in consecutive cycles; rom_addr=0x000 during BEAT1.
REQ-024 Contention: req0 and req1 held high continuously after reset, each dropped for one cycle after its gnt and then raised again -> grant order 0,1,0,1; never two gnt high in the same cycle.
REQ-025 Reset mid-burst: rst=1 during BEAT0 of a 2-byte read -> the next cycle has busy=0 and rd_valid=0, and no second byte is ever delivered.
REQ-026 Busy ignore: req1 pulsed high only while busy=1 -> no gnt1 and no rd_valid with rd_id=1.
REQ-027 Idle: no requests for 20 cycles -> gnt0, gnt1, rd_valid and busy all stay 0.
